// File: rtl/writeback_scheduler_pkg.sv
// Shared writeback types: the writeback payload and the output-slot state encoding.
package writeback_scheduler_pkg;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] value;
  } writeback_arbiter_data_t;

  typedef enum logic {
    WB_SLOT_EMPTY = 1'b0,
    WB_SLOT_FULL  = 1'b1
  } wb_slot_state_e;

endpackage

// File: rtl/wb_output_slot.sv
// One-entry registered writeback slot; can drain and refill in the same cycle.
module wb_output_slot
  import writeback_scheduler_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush_i,
  input  logic                    load_i,
  input  writeback_arbiter_data_t load_data_i,
  input  logic                    ready_i,
  output logic                    valid_o,
  output logic                    free_o,
  output writeback_arbiter_data_t data_o
);

  wb_slot_state_e          state_q, state_d;
  writeback_arbiter_data_t data_q, data_d;

  assign valid_o = (state_q == WB_SLOT_FULL);
  assign free_o  = (state_q == WB_SLOT_EMPTY) || ready_i;
  assign data_o  = data_q;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    if (flush_i) begin
      state_d = WB_SLOT_EMPTY;
    end else if (load_i) begin
      state_d = WB_SLOT_FULL;
      data_d  = load_data_i;
    end else if (state_q == WB_SLOT_FULL && ready_i) begin
      state_d = WB_SLOT_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= WB_SLOT_EMPTY;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/writeback_scheduler.sv
// Post office / mailbox writeback scheduler with starvation-bounded fixed priority.
// Optional statistics ports enabled by WRITEBACK_SCHEDULER_STATS_EN.
module writeback_scheduler
  import writeback_scheduler_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_W        = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    postoffice_writeback_arbiter_valid,
  output logic                    writeback_arbiter_postoffice_acknowledge,
  input  writeback_arbiter_data_t postoffice_writeback_arbiter_data,
  input  logic                    mailbox_writeback_arbiter_valid,
  output logic                    writeback_arbiter_mailbox_acknowledge,
  input  writeback_arbiter_data_t mailbox_writeback_arbiter_data,
  output logic                    writeback_arbiter_wb_valid,
  input  logic                    wb_writeback_arbiter_ready,
  output writeback_arbiter_data_t writeback_arbiter_wb_data
`ifdef WRITEBACK_SCHEDULER_STATS_EN
  ,
  output logic [31:0]             stat_postoffice_grants,
  output logic [31:0]             stat_mailbox_grants,
  output logic [31:0]             stat_wb_stall_cycles
`endif
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic                    slot_free;
  logic                    can_grant, force_mb, grant_po, grant_mb;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  writeback_arbiter_data_t load_data;

  assign can_grant = slot_free && !flush && !rst;
  assign force_mb  = mailbox_writeback_arbiter_valid && (cnt_q >= LIMIT);
  assign grant_mb  = can_grant && (force_mb ||
                     (!postoffice_writeback_arbiter_valid && mailbox_writeback_arbiter_valid));
  assign grant_po  = can_grant && !force_mb && postoffice_writeback_arbiter_valid;
  assign load_data = grant_mb ? mailbox_writeback_arbiter_data
                              : postoffice_writeback_arbiter_data;

  assign writeback_arbiter_postoffice_acknowledge = grant_po;
  assign writeback_arbiter_mailbox_acknowledge    = grant_mb;

  // Counts post-office wins while the mailbox waits; saturates at the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (flush) begin
      cnt_d = '0;
    end else if (grant_po && mailbox_writeback_arbiter_valid) begin
      if (cnt_q < LIMIT) cnt_d = cnt_q + CNT_W'(1);
    end else if (grant_mb || !mailbox_writeback_arbiter_valid) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  wb_output_slot u_slot (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flush),
    .load_i      (grant_po || grant_mb),
    .load_data_i (load_data),
    .ready_i     (wb_writeback_arbiter_ready),
    .valid_o     (writeback_arbiter_wb_valid),
    .free_o      (slot_free),
    .data_o      (writeback_arbiter_wb_data)
  );

`ifdef WRITEBACK_SCHEDULER_STATS_EN
  logic [31:0] stat_po_q, stat_mb_q, stat_stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_po_q    <= '0;
      stat_mb_q    <= '0;
      stat_stall_q <= '0;
    end else begin
      if (grant_po) stat_po_q <= stat_po_q + 32'd1;
      if (grant_mb) stat_mb_q <= stat_mb_q + 32'd1;
      if (writeback_arbiter_wb_valid && !wb_writeback_arbiter_ready)
        stat_stall_q <= stat_stall_q + 32'd1;
    end
  end

  assign stat_postoffice_grants = stat_po_q;
  assign stat_mailbox_grants    = stat_mb_q;
  assign stat_wb_stall_cycles   = stat_stall_q;
`endif

endmodule
